// File: rtl/ecc_lockstep_fault_mon_if.sv
// rtl/ecc_lockstep_fault_mon_if.sv - read-path beat, control and status bundle for the lockstep ECC monitor
interface ecc_lockstep_fault_mon_if #(
    parameter int DATA_WIDTH   = 107,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_W        = 8
);
    logic                    vld_in;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [PARITY_WIDTH-1:0] parity_in;
    logic                    bypass;
    logic                    ecc_fault_detc_en;
    logic                    dbg_inj;
    logic                    selftest_req;
    logic                    clr;
    logic                    vld_out;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    sbit_err;
    logic                    dbit_err;
    logic                    ecc_fault;
    logic [CNT_W-1:0]        sbit_cnt;
    logic [CNT_W-1:0]        dbit_cnt;
    logic [CNT_W-1:0]        fault_cnt;
    logic                    fault_alarm;
    logic                    selftest_busy;
    logic                    selftest_done;
    logic                    selftest_pass;

    modport master (
        output vld_in, data_in, parity_in, bypass, ecc_fault_detc_en, dbg_inj, selftest_req, clr,
        input  vld_out, data_out, sbit_err, dbit_err, ecc_fault, sbit_cnt, dbit_cnt, fault_cnt,
               fault_alarm, selftest_busy, selftest_done, selftest_pass
    );

    modport slave (
        input  vld_in, data_in, parity_in, bypass, ecc_fault_detc_en, dbg_inj, selftest_req, clr,
        output vld_out, data_out, sbit_err, dbit_err, ecc_fault, sbit_cnt, dbit_cnt, fault_cnt,
               fault_alarm, selftest_busy, selftest_done, selftest_pass
    );
endinterface

// File: rtl/ecc_lockstep_fault_mon.sv
// rtl/ecc_lockstep_fault_mon.sv - dual SECDED decode with lockstep compare, counters and self-test
module ecc_cal #(
    parameter int DATA_WIDTH   = 107,
    parameter int PARITY_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [PARITY_WIDTH-1:0] parity,
    input  logic                    bypass,
    output logic [DATA_WIDTH-1:0]   mask,
    output logic                    sbit_err,
    output logic                    dbit_err
);
    localparam int CHK = PARITY_WIDTH - 1;

    // Data bit idx sits at the idx-th non-power-of-two Hamming position; the top parity bit is overall parity.
    function automatic int data_pos(input int idx);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int p = 3; p < (1 << PARITY_WIDTH); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = p;
                n++;
            end
        end
        return r;
    endfunction

    logic [CHK-1:0]        term [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] hit;
    logic [CHK-1:0]        syn;
    logic                  ov;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
        localparam logic [CHK-1:0] POS = CHK'(data_pos(g));
        assign term[g] = data[g] ? POS : '0;
        assign hit[g]  = (syn == POS);
    end

    always_comb begin
        syn = parity[CHK-1:0];
        for (int i = 0; i < DATA_WIDTH; i++) syn = syn ^ term[i];
    end

    assign ov = ^{data, parity};

    always_comb begin
        sbit_err = 1'b0;
        dbit_err = 1'b0;
        mask     = '0;
        if (!bypass) begin
            if (ov) begin
                sbit_err = 1'b1;
                mask     = hit;
            end else if (syn != '0) begin
                dbit_err = 1'b1;
            end
        end
    end
endmodule

module ecc_lockstep_fault_mon #(
    parameter int DATA_WIDTH   = 107,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_W        = 8,
    parameter int FAULT_THRESH = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    ecc_lockstep_fault_mon_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DONE} st_t;

    st_t                   state, state_nxt;
    logic [DATA_WIDTH-1:0] mask0, mask1, mask1_x, data_sel;
    logic                  sb0, db0, sb1, db1;
    logic                  armed, mis, rf;
    logic [CNT_W-1:0]      sbit_nxt, dbit_nxt, fault_nxt;

    logic                  vld_q, sb_q, db_q, flt_q, alarm_q, pass_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      sbit_q, dbit_q, fault_q;

    ecc_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_core0 (
        .data(bus.data_in), .parity(bus.parity_in), .bypass(bus.bypass),
        .mask(mask0), .sbit_err(sb0), .dbit_err(db0)
    );

    ecc_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_core1 (
        .data(bus.data_in), .parity(bus.parity_in), .bypass(bus.bypass),
        .mask(mask1), .sbit_err(sb1), .dbit_err(db1)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != '1)) ? c + 1'b1 : c;
    endfunction

    // Self-test flips the same core-1 bit as debug injection, so a healthy comparator must report a mismatch.
    assign armed     = (state == ST_ARMED);
    assign mask1_x   = mask1 ^ DATA_WIDTH'(armed | bus.dbg_inj);
    assign mis       = |({sb0, db0, mask0} ^ {sb1, db1, mask1_x});
    assign rf        = bus.vld_in & mis & bus.ecc_fault_detc_en & ~armed;
    assign data_sel  = rf ? bus.data_in : (bus.data_in ^ mask0);
    assign sbit_nxt  = sat_inc(sbit_q, bus.vld_in & sb0);
    assign dbit_nxt  = sat_inc(dbit_q, bus.vld_in & db0);
    assign fault_nxt = sat_inc(fault_q, rf);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.selftest_req) state_nxt = ST_ARMED;
            ST_ARMED: if (bus.vld_in) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            vld_q   <= 1'b0;
            data_q  <= '0;
            sb_q    <= 1'b0;
            db_q    <= 1'b0;
            flt_q   <= 1'b0;
            sbit_q  <= '0;
            dbit_q  <= '0;
            fault_q <= '0;
            alarm_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= bus.vld_in;
            if (bus.vld_in) begin
                data_q <= data_sel;
                sb_q   <= sb0;
                db_q   <= db0;
                flt_q  <= rf;
            end
            if (armed && bus.vld_in) pass_q <= mis;
            if (bus.clr) begin
                sbit_q  <= '0;
                dbit_q  <= '0;
                fault_q <= '0;
                alarm_q <= 1'b0;
            end else begin
                sbit_q  <= sbit_nxt;
                dbit_q  <= dbit_nxt;
                fault_q <= fault_nxt;
                if (fault_nxt >= CNT_W'(FAULT_THRESH)) alarm_q <= 1'b1;
            end
        end
    end

    assign bus.vld_out       = vld_q;
    assign bus.data_out      = data_q;
    assign bus.sbit_err      = sb_q;
    assign bus.dbit_err      = db_q;
    assign bus.ecc_fault     = flt_q & vld_q;
    assign bus.sbit_cnt      = sbit_q;
    assign bus.dbit_cnt      = dbit_q;
    assign bus.fault_cnt     = fault_q;
    assign bus.fault_alarm   = alarm_q;
    assign bus.selftest_busy = armed;
    assign bus.selftest_done = (state == ST_DONE);
    assign bus.selftest_pass = pass_q;
endmodule

// File: tb/tb_ecc_lockstep_fault_mon.sv
// tb/tb_ecc_lockstep_fault_mon.sv - scoreboard bench for the lockstep ECC fault monitor
module tb_ecc_lockstep_fault_mon;
    localparam int DW = 107;
    localparam int PW = 8;
    localparam int CW = 4;
    localparam int TH = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecc_lockstep_fault_mon_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_W(CW)) bus ();

    ecc_lockstep_fault_mon #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_W(CW), .FAULT_THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sb, db, flt, al, done, pass;
        int            sc, dc, fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_sc, m_dc, m_fc;
    logic m_al, m_pass, m_armed;
    logic started = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference Hamming encoder: walk codeword positions, skip power-of-two slots, assign data bits in order.
    function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
        logic [PW-2:0] s;
        int            idx;
        s   = '0;
        idx = 0;
        for (int p = 1; p < 128; p++) begin
            if (((p & (p - 1)) != 0) && (idx < DW)) begin
                if (d[idx]) s = s ^ 7'(p);
                idx++;
            end
        end
        return {(^d) ^ (^s), s};
    endfunction

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        m_sc = 0; m_dc = 0; m_fc = 0;
        m_al = 1'b0; m_pass = 1'b0; m_armed = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] orig, input int kind, input int b0, input int b1,
                        input logic inj, input logic en, input logic byp, input logic clr_i);
        logic [DW-1:0] raw;
        logic          mis, rf;
        exp_t          e;
        raw = orig;
        if (kind >= 1) raw[b0] = ~raw[b0];
        if (kind == 2) raw[b1] = ~raw[b1];
        @(negedge clk);
        bus.vld_in = 1'b1; bus.data_in = raw; bus.parity_in = enc(orig);
        bus.bypass = byp; bus.ecc_fault_detc_en = en; bus.dbg_inj = inj;
        bus.clr = clr_i; bus.selftest_req = 1'b0;
        mis    = inj | m_armed;
        rf     = mis & en & ~m_armed;
        e.sb   = (kind == 1) && !byp;
        e.db   = (kind == 2) && !byp;
        e.flt  = rf;
        e.data = rf ? raw : (e.sb ? orig : raw);
        if (clr_i) begin
            m_sc = 0; m_dc = 0; m_fc = 0; m_al = 1'b0;
        end else begin
            m_sc = sat(m_sc + int'(e.sb));
            m_dc = sat(m_dc + int'(e.db));
            m_fc = sat(m_fc + int'(rf));
            if (m_fc >= TH) m_al = 1'b1;
        end
        e.done = m_armed;
        if (m_armed) m_pass = mis;
        m_armed = 1'b0;
        e.pass = m_pass;
        e.sc = m_sc; e.dc = m_dc; e.fc = m_fc; e.al = m_al;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.vld_in = 1'b0; bus.clr = 1'b0; bus.selftest_req = 1'b0;
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_sc"}, bus.sbit_cnt, m_sc);
        check({tag, "_dc"}, bus.dbit_cnt, m_dc);
        check({tag, "_fc"}, bus.fault_cnt, m_fc);
        check({tag, "_al"}, bus.fault_alarm, m_al);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (bus.vld_out) begin
                if (q.size() == 0) begin
                    check("unexpected_vld_out", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("data_out", bus.data_out, e.data);
                    check("sbit_err", bus.sbit_err, e.sb);
                    check("dbit_err", bus.dbit_err, e.db);
                    check("ecc_fault", bus.ecc_fault, e.flt);
                    check("sbit_cnt", bus.sbit_cnt, e.sc);
                    check("dbit_cnt", bus.dbit_cnt, e.dc);
                    check("fault_cnt", bus.fault_cnt, e.fc);
                    check("fault_alarm", bus.fault_alarm, e.al);
                    check("selftest_done", bus.selftest_done, e.done);
                    check("selftest_pass", bus.selftest_pass, e.pass);
                end
            end else begin
                check("idle_ecc_fault", bus.ecc_fault, 0);
                check("idle_selftest_done", bus.selftest_done, 0);
            end
        end
    end

    initial begin
        logic [DW-1:0] w;
        bus.vld_in = 1'b0; bus.data_in = '0; bus.parity_in = '0; bus.bypass = 1'b0;
        bus.ecc_fault_detc_en = 1'b1; bus.dbg_inj = 1'b0; bus.selftest_req = 1'b0; bus.clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_vld_out", bus.vld_out, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_busy", bus.selftest_busy, 0);
        check("rst_pass", bus.selftest_pass, 0);
        check_counters("rst");
        rst_n   = 1'b1;
        started = 1'b1;

        w = {$urandom, $urandom, $urandom, $urandom};
        beat(w, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(w, 1, 40, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(~w, 2, 3, 90, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(w, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(w, 1, 106, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(w, 1, 17, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(w, 2, 5, 6, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("hold_data_out", bus.data_out, w ^ (107'(1) << 5) ^ (107'(1) << 6));

        for (int i = 0; i < 23; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            beat(w, (i == 1) ? 1 : 0, 9, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        idle(2);
        check_counters("sat");

        @(negedge clk);
        bus.clr = 1'b1;
        m_sc = 0; m_dc = 0; m_fc = 0; m_al = 1'b0;
        idle(1);
        check_counters("clr");

        beat(w, 1, 77, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        beat(w, 1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(w, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        beat(w, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        @(negedge clk);
        bus.selftest_req = 1'b1;
        m_armed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("busy_armed", bus.selftest_busy, 1);
        end
        beat(w, 1, 33, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("busy_after", bus.selftest_busy, 0);
        idle(2);

        beat(w, 1, 50, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(w, 2, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        bus.selftest_req = 1'b1;
        idle(2);
        check("busy_pre_rst", bus.selftest_busy, 1);
        rst_n = 1'b0;
        model_reset();
        idle(2);
        check("rst_busy2", bus.selftest_busy, 0);
        check("rst_pass2", bus.selftest_pass, 0);
        check("rst_vld_out2", bus.vld_out, 0);
        check_counters("rst2");
        rst_n = 1'b1;
        idle(3);
        check("rst_busy3", bus.selftest_busy, 0);
        check("q_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ecc_lockstep_fault_mon.md
# ecc_lockstep_fault_mon

Registered, parametrised lockstep checker for a SECDED read path. Two identical SECDED decode cores (`ecc_cal`, parameterised by DATA_WIDTH/PARITY_WIDTH) run on every valid beat. Their syndrome results are compared, and on a mismatch the raw word is forwarded instead of the corrected one. The block adds per-beat valid tracking, saturating error/fault counters, a sticky fault alarm, and an on-demand self-test sequencer that proves the comparator works. It sits between the FIFO/RAM read port and the consumer, and its fault outputs feed the safety aggregator.

## Interface
- DATA_WIDTH, 107, protected data width.
- PARITY_WIDTH, 8, SECDED check-bit width.
- CNT_W, 8, width of each saturating counter.
- FAULT_THRESH, 1, fault count at which `fault_alarm` sets; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- vld_in  in  1  input beat valid.
- data_in  in  DATA_WIDTH  read data.
- parity_in  in  PARITY_WIDTH  stored check bits.
- bypass  in  1  passed to both cores (no correction, no flags).
- ecc_fault_detc_en  in  1  enables fault handling.
- dbg_inj  in  1  test input; XORs core-1 mask bit 0 on every valid beat, and the result is treated as a real fault.
- selftest_req  in  1  one-cycle pulse that requests a self-test.
- clr  in  1  synchronous clear of counters and alarm.
- vld_out  out  1  output beat valid.
- data_out  out  DATA_WIDTH  corrected data, or raw data on a fault.
- sbit_err, dbit_err  out  1 each  core-0 flags for the output beat.
- ecc_fault  out  1  lockstep mismatch on the output beat.
- sbit_cnt, dbit_cnt, fault_cnt  out  CNT_W each  saturating counters.
- fault_alarm  out  1  sticky; set when fault_cnt ≥ FAULT_THRESH.
- selftest_busy  out  1  high in the ARMED state.
- selftest_done  out  1  one-cycle pulse when a self-test completes.
- selftest_pass  out  1  result of the last self-test; holds until the next completion.

## Operation
- Both cores decode `data_in` and `parity_in` combinationally.
- Mismatch is defined as mis = |({sb0,db0,mask0} ^ {sb1,db1,mask1'}).
  - mask1' is mask1 with bit 0 inverted when `dbg_inj` is high or the FSM is in ARMED.
- Real fault: rf = vld_in & mis & ecc_fault_detc_en & ~ARMED.
- Output data selection:
  - rf = 1: `data_in` (raw).
  - Otherwise: core-0 corrected data.
  - Self-test beats always output core-0 data.
- Self-test FSM states: IDLE, ARMED, DONE.
  - IDLE → ARMED when `selftest_req` = 1.
  - ARMED → DONE on the first cycle with `vld_in` = 1. `selftest_pass` is loaded with `mis` from that beat, independent of `ecc_fault_detc_en`.
  - DONE → IDLE unconditionally. `selftest_done` is high for exactly this one cycle.
  - `selftest_req` in ARMED or DONE is ignored.
  - A self-test beat never asserts `ecc_fault` and never increments `fault_cnt`. Its `sbit_cnt`/`dbit_cnt` updates follow core 0 as normal.
- Counters (all saturate at 2^CNT_W-1, never wrap):
  - `sbit_cnt` += vld_in & sb0.
  - `dbit_cnt` += vld_in & db0.
  - `fault_cnt` += rf.
- `fault_alarm` sets on the edge where the next fault_cnt value ≥ FAULT_THRESH. It clears only on `clr` or reset.
- `clr` has priority: when `clr` and an increment coincide, counters and alarm go to 0 and the increment is lost. `clr` does not affect the FSM, the datapath, or `selftest_pass`.
- With `bypass` = 1, both cores report no errors. Any mismatch then comes only from injection.

## Timing
- Latency is 1 cycle. `vld_out`, `data_out`, `sbit_err`, `dbit_err` and `ecc_fault` are registered from beat N and valid in cycle N+1.
- `data_out` and the flags update only when `vld_in` = 1 and hold otherwise. `ecc_fault` is 0 when `vld_out` = 0.
- Counters, `fault_alarm` and `selftest_pass` update on the same edge as the beat's outputs.
- `selftest_done` rises in the cycle after the tested beat, together with that beat's `vld_out`.
- Throughput is one beat per cycle with no backpressure.
- Reset: all outputs are 0 and the FSM is in IDLE, including `data_out` and `selftest_pass`.
  - Reset mid self-test aborts it with no `selftest_done` pulse.
  - Reset release is internally synchronised to `clk` by the integrator.

## Test plan
All scenarios use DATA_WIDTH=107, PARITY_WIDTH=8, CNT_W=4, FAULT_THRESH=3.
- Clean word plus a single-bit flip at bit 40, vld_in=1 → next cycle: vld_out=1, data_out=original, sbit_err=1, ecc_fault=0, sbit_cnt=1.
- Double-bit flip at bits 3 and 90 → dbit_err=1, dbit_cnt=1, fault_cnt unchanged.
- dbg_inj=1, en=1, three valid beats → ecc_fault=1 each cycle, data_out=raw data_in, fault_cnt 1→2→3, fault_alarm=1 after the third beat. Then 20 more beats → fault_cnt saturates at 15. Then clr → all counters 0 and alarm 0.
- dbg_inj=1, en=0 → ecc_fault=0, corrected data out, fault_cnt stays 0.
- selftest_req pulse, no vld for 5 cycles, then one vld beat → selftest_busy=1 until that beat, then selftest_done pulse with selftest_pass=1, ecc_fault=0, fault_cnt=0.
- rst_n low while ARMED → busy=0, no done pulse, all counters 0.
